// File: rtl/multi_car_collision_resolver.sv
// multi_car_collision_resolver
//   Sequential N-car collision resolver. On a start request it captures all car
//   states, walks every unordered pair (i<j) in lexicographic order and, for each
//   colliding pair, applies the mass-weighted elastic-impulse velocity update with
//   one shared restoring divider. Later pairs see velocities already updated by
//   earlier pairs.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start               one-cycle start request, taken only while idle
//   i_pos_x/i_pos_y       signed positions, car k at [k*POS_W +: POS_W]
//   i_vel_x/i_vel_y       signed velocities, car k at [k*VEL_W +: VEL_W]
//   i_radius, i_mass      signed radii / unsigned mass levels, same packing
//   o_vel_x/o_vel_y       resolved velocities, held until the next pass or reset
//   o_hit_mask            bit k set if car k collided at least once this pass
//   o_busy                high from the cycle after start acceptance through DONE
//   o_done                one-cycle pulse; results valid from this cycle
module multi_car_collision_resolver #(
   parameter int unsigned NUM_CARS = 4,
   parameter int unsigned POS_W    = 12,
   parameter int unsigned VEL_W    = 16,
   parameter int unsigned RAD_W    = 8,
   parameter int unsigned MASS_W   = 3,
   parameter int unsigned DIV_W    = 64
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_start,
   input  logic [NUM_CARS*POS_W-1:0]    i_pos_x,
   input  logic [NUM_CARS*POS_W-1:0]    i_pos_y,
   input  logic [NUM_CARS*VEL_W-1:0]    i_vel_x,
   input  logic [NUM_CARS*VEL_W-1:0]    i_vel_y,
   input  logic [NUM_CARS*RAD_W-1:0]    i_radius,
   input  logic [NUM_CARS*MASS_W-1:0]   i_mass,
   output logic [NUM_CARS*VEL_W-1:0]    o_vel_x,
   output logic [NUM_CARS*VEL_W-1:0]    o_vel_y,
   output logic [NUM_CARS-1:0]          o_hit_mask,
   output logic                         o_busy,
   output logic                         o_done
);

   localparam int unsigned IDX_W = $clog2(NUM_CARS);
   localparam int unsigned DX_W  = POS_W + 1;
   localparam int unsigned DV_W  = VEL_W + 1;
   localparam int unsigned D2_W  = 2*DX_W + 1;
   localparam int unsigned DOT_W = DV_W + DX_W + 1;
   localparam int unsigned S_W   = MASS_W + D2_W + 2;
   localparam int unsigned NA_W  = S_W + VEL_W + 1;
   localparam int unsigned NB_W  = MASS_W + DOT_W + DX_W + 3;
   localparam int unsigned NUM_W = ((NA_W > NB_W) ? NA_W : NB_W) + 1;
   // Common arithmetic width: wide enough to hold every intermediate exactly
   localparam int unsigned CW    = (NUM_W > DIV_W) ? NUM_W : DIV_W;
   localparam int unsigned CNT_W = $clog2(DIV_W + 1);

   localparam logic [DIV_W-1:0]        SAT_LIM = DIV_W'(1) << (VEL_W - 1);
   localparam logic signed [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W-1){1'b0}}};
   localparam logic signed [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};

   typedef logic signed [CW-1:0] wide_t;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_TEST, S_DIV, S_WRITE, S_NEXT, S_DONE
   } state_t;

   state_t state, state_nx;

   logic signed [POS_W-1:0] px  [NUM_CARS];
   logic signed [POS_W-1:0] py  [NUM_CARS];
   logic signed [VEL_W-1:0] vx  [NUM_CARS];
   logic signed [VEL_W-1:0] vy  [NUM_CARS];
   logic signed [RAD_W-1:0] rad [NUM_CARS];
   logic [MASS_W-1:0]       mass[NUM_CARS];
   logic [NUM_CARS-1:0]     hit;
   logic [IDX_W-1:0]        idx_i, idx_j;

   wide_t t_dx, t_dy, t_dot, t_s;
   logic [1:0]              q_idx;
   logic [CNT_W-1:0]        div_cnt;
   logic [DIV_W-1:0]        quo, den, rem;
   logic                    neg;
   logic signed [VEL_W-1:0] q_res [4];

   wide_t c_dx, c_dy, c_dvx, c_dvy, c_d2, c_rs, c_r2, c_dot, c_mi, c_mj, c_s;
   logic  collide_c, last_pair_c, last_iter_c;
   wide_t m_other_c, d_sel_c, v_sel_c, term_c, num_c;
   logic  num_neg_c, den_neg_c;
   logic [DIV_W-1:0]        num_mag_c, den_mag_c, quo_nx_c, rem_nx_c;
   logic [DIV_W:0]          rem_sh_c, diff_c;
   logic signed [VEL_W-1:0] q_fin_c;

   // Pair geometry and collision test on the working registers
   always_comb begin
      c_dx  = wide_t'(px[idx_i]) - wide_t'(px[idx_j]);
      c_dy  = wide_t'(py[idx_i]) - wide_t'(py[idx_j]);
      c_dvx = wide_t'(vx[idx_i]) - wide_t'(vx[idx_j]);
      c_dvy = wide_t'(vy[idx_i]) - wide_t'(vy[idx_j]);
      c_d2  = c_dx*c_dx + c_dy*c_dy;
      c_rs  = wide_t'(rad[idx_i]) + wide_t'(rad[idx_j]);
      c_r2  = c_rs*c_rs;
      c_dot = c_dvx*c_dx + c_dvy*c_dy;
      c_mi  = wide_t'({1'b0, mass[idx_i]});
      c_mj  = wide_t'({1'b0, mass[idx_j]});
      c_s   = (c_mi + c_mj)*c_d2;
      collide_c   = (c_d2 <= c_r2) && c_dot[CW-1] && (c_s != '0);
      last_pair_c = (idx_i == IDX_W'(NUM_CARS-2)) && (idx_j == IDX_W'(NUM_CARS-1));
      last_iter_c = (div_cnt == CNT_W'(DIV_W));
   end

   // Numerator for the current quotient: q_idx 0/1 = car i x/y, 2/3 = car j x/y
   always_comb begin
      m_other_c = q_idx[1] ? c_mi : c_mj;
      d_sel_c   = q_idx[0] ? t_dy : t_dx;
      case (q_idx)
         2'd0:    v_sel_c = wide_t'(vx[idx_i]);
         2'd1:    v_sel_c = wide_t'(vy[idx_i]);
         2'd2:    v_sel_c = wide_t'(vx[idx_j]);
         default: v_sel_c = wide_t'(vy[idx_j]);
      endcase
      term_c    = m_other_c*t_dot*d_sel_c;
      num_c     = q_idx[1] ? (t_s*v_sel_c + term_c + term_c)
                           : (t_s*v_sel_c - term_c - term_c);
      num_neg_c = num_c[DIV_W-1];
      den_neg_c = t_s[DIV_W-1];
      num_mag_c = num_neg_c ? -num_c[DIV_W-1:0] : num_c[DIV_W-1:0];
      den_mag_c = den_neg_c ? -t_s[DIV_W-1:0]   : t_s[DIV_W-1:0];
   end

   // One restoring-division step on magnitudes, then sign and saturation
   always_comb begin
      rem_sh_c = {rem, quo[DIV_W-1]};
      diff_c   = rem_sh_c - {1'b0, den};
      quo_nx_c = {quo[DIV_W-2:0], ~diff_c[DIV_W]};
      rem_nx_c = diff_c[DIV_W] ? rem_sh_c[DIV_W-1:0] : diff_c[DIV_W-1:0];
      if (neg) begin
         q_fin_c = (quo_nx_c > SAT_LIM) ? VEL_MIN : -quo_nx_c[VEL_W-1:0];
      end else begin
         q_fin_c = (quo_nx_c >= SAT_LIM) ? VEL_MAX : quo_nx_c[VEL_W-1:0];
      end
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (i_start) state_nx = S_LOAD;
         S_LOAD:  state_nx = S_TEST;
         S_TEST:  state_nx = collide_c ? S_DIV : S_NEXT;
         S_DIV:   if (last_iter_c && (q_idx == 2'd3)) state_nx = S_WRITE;
         S_WRITE: state_nx = S_NEXT;
         S_NEXT:  state_nx = last_pair_c ? S_DONE : S_TEST;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         idx_i      <= '0;
         idx_j      <= '0;
         hit        <= '0;
         q_idx      <= '0;
         div_cnt    <= '0;
         o_vel_x    <= '0;
         o_vel_y    <= '0;
         o_hit_mask <= '0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
      end else begin
         o_busy <= (state_nx != S_IDLE);
         o_done <= (state_nx == S_DONE);
         case (state)
            S_LOAD: begin
               for (int k = 0; k < NUM_CARS; k++) begin
                  px[k]   <= i_pos_x[k*POS_W +: POS_W];
                  py[k]   <= i_pos_y[k*POS_W +: POS_W];
                  vx[k]   <= i_vel_x[k*VEL_W +: VEL_W];
                  vy[k]   <= i_vel_y[k*VEL_W +: VEL_W];
                  rad[k]  <= i_radius[k*RAD_W +: RAD_W];
                  mass[k] <= i_mass[k*MASS_W +: MASS_W];
               end
               hit   <= '0;
               idx_i <= '0;
               idx_j <= IDX_W'(1);
            end
            S_TEST: begin
               t_dx    <= c_dx;
               t_dy    <= c_dy;
               t_dot   <= c_dot;
               t_s     <= c_s;
               q_idx   <= '0;
               div_cnt <= '0;
            end
            S_DIV: begin
               // div_cnt 0 is the setup cycle, 1..DIV_W are iteration cycles
               if (div_cnt == '0) begin
                  quo     <= num_mag_c;
                  den     <= den_mag_c;
                  rem     <= '0;
                  neg     <= num_neg_c ^ den_neg_c;
                  div_cnt <= CNT_W'(1);
               end else begin
                  quo <= quo_nx_c;
                  rem <= rem_nx_c;
                  if (last_iter_c) begin
                     q_res[q_idx] <= q_fin_c;
                     q_idx        <= q_idx + 2'd1;
                     div_cnt      <= '0;
                  end else begin
                     div_cnt <= div_cnt + CNT_W'(1);
                  end
               end
            end
            S_WRITE: begin
               vx[idx_i]  <= q_res[0];
               vy[idx_i]  <= q_res[1];
               vx[idx_j]  <= q_res[2];
               vy[idx_j]  <= q_res[3];
               hit[idx_i] <= 1'b1;
               hit[idx_j] <= 1'b1;
            end
            S_NEXT: begin
               if (last_pair_c) begin
                  // Results are published on entry to DONE so they are valid with o_done
                  for (int k = 0; k < NUM_CARS; k++) begin
                     o_vel_x[k*VEL_W +: VEL_W] <= vx[k];
                     o_vel_y[k*VEL_W +: VEL_W] <= vy[k];
                  end
                  o_hit_mask <= hit;
               end else if (idx_j == IDX_W'(NUM_CARS-1)) begin
                  idx_i <= idx_i + IDX_W'(1);
                  idx_j <= idx_i + IDX_W'(2);
               end else begin
                  idx_j <= idx_j + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multi_car_collision_resolver.sv
// tb_multi_car_collision_resolver
//   Scoreboard bench: expected results are queued when a pass is started and
//   compared when the DUT pulses o_done. Instance A uses default parameters,
//   instance B (2 cars, 8-bit velocity, 4-bit mass) covers truncation/saturation.
module tb_multi_car_collision_resolver;

   localparam int unsigned N   = 4;
   localparam int unsigned PW  = 12;
   localparam int unsigned VW  = 16;
   localparam int unsigned RW  = 8;
   localparam int unsigned MW  = 3;
   localparam int unsigned DW  = 64;
   localparam int unsigned NB  = 2;
   localparam int unsigned VWB = 8;
   localparam int unsigned MWB = 4;
   localparam int PA      = N*(N-1)/2;
   localparam int PB      = NB*(NB-1)/2;
   localparam int COLL_CY = 4*(DW+1) + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic rst, start_a, start_b;

   logic [N*PW-1:0]  pos_x_a, pos_y_a;
   logic [N*VW-1:0]  vel_x_a, vel_y_a, out_vx_a, out_vy_a;
   logic [N*RW-1:0]  rad_a;
   logic [N*MW-1:0]  mass_a;
   logic [N-1:0]     hit_a;
   logic             busy_a, done_a;

   logic [NB*PW-1:0]  pos_x_b, pos_y_b;
   logic [NB*VWB-1:0] vel_x_b, vel_y_b, out_vx_b, out_vy_b;
   logic [NB*RW-1:0]  rad_b;
   logic [NB*MWB-1:0] mass_b;
   logic [NB-1:0]     hit_b;
   logic              busy_b, done_b;

   multi_car_collision_resolver #(
      .NUM_CARS(N), .POS_W(PW), .VEL_W(VW), .RAD_W(RW), .MASS_W(MW), .DIV_W(DW)
   ) dut_a (
      .i_clk(clk), .i_rst(rst), .i_start(start_a),
      .i_pos_x(pos_x_a), .i_pos_y(pos_y_a), .i_vel_x(vel_x_a), .i_vel_y(vel_y_a),
      .i_radius(rad_a), .i_mass(mass_a),
      .o_vel_x(out_vx_a), .o_vel_y(out_vy_a), .o_hit_mask(hit_a),
      .o_busy(busy_a), .o_done(done_a)
   );

   multi_car_collision_resolver #(
      .NUM_CARS(NB), .POS_W(PW), .VEL_W(VWB), .RAD_W(RW), .MASS_W(MWB), .DIV_W(DW)
   ) dut_b (
      .i_clk(clk), .i_rst(rst), .i_start(start_b),
      .i_pos_x(pos_x_b), .i_pos_y(pos_y_b), .i_vel_x(vel_x_b), .i_vel_y(vel_y_b),
      .i_radius(rad_b), .i_mass(mass_b),
      .o_vel_x(out_vx_b), .o_vel_y(out_vy_b), .o_hit_mask(hit_b),
      .o_busy(busy_b), .o_done(done_b)
   );

   typedef struct packed {
      logic [N*VW-1:0] vx;
      logic [N*VW-1:0] vy;
      logic [N-1:0]    mask;
      int              lat;
      int              t0;
   } exp_a_t;

   typedef struct packed {
      logic [NB*VWB-1:0] vx;
      logic [NB*VWB-1:0] vy;
      logic [NB-1:0]     mask;
      int                lat;
      int                t0;
   } exp_b_t;

   exp_a_t sb_a[$];
   exp_b_t sb_b[$];
   exp_a_t ea;
   exp_b_t eb;
   int     ex_vx[N];
   int     ex_vy[N];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive car k of instance A; the expected result defaults to "unchanged"
   task automatic set_car(input int k, input int x, input int y, input int vx,
                          input int vy, input int r, input int m);
      pos_x_a[k*PW +: PW] = PW'(x);
      pos_y_a[k*PW +: PW] = PW'(y);
      vel_x_a[k*VW +: VW] = VW'(vx);
      vel_y_a[k*VW +: VW] = VW'(vy);
      rad_a[k*RW +: RW]   = RW'(r);
      mass_a[k*MW +: MW]  = MW'(m);
      ex_vx[k] = vx;
      ex_vy[k] = vy;
   endtask

   task automatic go_a(input logic [N-1:0] mask, input int ncoll);
      exp_a_t e;
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         e.vx[k*VW +: VW] = VW'(ex_vx[k]);
         e.vy[k*VW +: VW] = VW'(ex_vy[k]);
      end
      e.mask = mask;
      e.lat  = 2 + 2*PA + ncoll*COLL_CY;
      e.t0   = cyc;
      sb_a.push_back(e);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
   endtask

   task automatic drain_a(input int budget);
      int n = 0;
      while (sb_a.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (sb_a.size() != 0) begin
         check_eq("a_timeout_pending", sb_a.size(), 0);
         sb_a.delete();
      end
      repeat (2) @(posedge clk);
   endtask

   // Scoreboard monitor, instance A
   always @(posedge clk) begin
      #1;
      if (done_a) begin
         if (sb_a.size() == 0) begin
            check_eq("a_done_without_pass", longint'(done_a), 0);
         end else begin
            ea = sb_a.pop_front();
            for (int k = 0; k < N; k++) begin
               check_eq($sformatf("a_vx%0d", k), longint'($signed(out_vx_a[k*VW +: VW])),
                        longint'($signed(ea.vx[k*VW +: VW])));
               check_eq($sformatf("a_vy%0d", k), longint'($signed(out_vy_a[k*VW +: VW])),
                        longint'($signed(ea.vy[k*VW +: VW])));
            end
            check_eq("a_mask", longint'(hit_a), longint'(ea.mask));
            check_eq("a_latency", cyc - ea.t0, ea.lat);
            check_eq("a_busy_in_done", longint'(busy_a), 1);
         end
      end
   end

   // Scoreboard monitor, instance B
   always @(posedge clk) begin
      #1;
      if (done_b) begin
         if (sb_b.size() == 0) begin
            check_eq("b_done_without_pass", longint'(done_b), 0);
         end else begin
            eb = sb_b.pop_front();
            for (int k = 0; k < NB; k++) begin
               check_eq($sformatf("b_vx%0d", k), longint'($signed(out_vx_b[k*VWB +: VWB])),
                        longint'($signed(eb.vx[k*VWB +: VWB])));
               check_eq($sformatf("b_vy%0d", k), longint'($signed(out_vy_b[k*VWB +: VWB])),
                        longint'($signed(eb.vy[k*VWB +: VWB])));
            end
            check_eq("b_mask", longint'(hit_b), longint'(eb.mask));
            check_eq("b_latency", cyc - eb.t0, eb.lat);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
      pos_x_a = '0; pos_y_a = '0; vel_x_a = '0; vel_y_a = '0; rad_a = '0; mass_a = '0;
      pos_x_b = '0; pos_y_b = '0; vel_x_b = '0; vel_y_b = '0; rad_b = '0; mass_b = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_vx_a", longint'(out_vx_a), 0);
      check_eq("rst_vy_a", longint'(out_vy_a), 0);
      check_eq("rst_mask_a", longint'(hit_a), 0);
      check_eq("rst_busy_a", longint'(busy_a), 0);
      check_eq("rst_done_a", longint'(done_a), 0);
      rst = 1'b0;

      // Head-on, equal mass; a second start mid-pass and input changes are ignored
      set_car(0, 0, 0, 16, 0, 8, 1);
      set_car(1, 10, 0, -16, 0, 8, 1);
      set_car(2, 1000, 1000, 0, 0, 8, 1);
      set_car(3, -1000, -1000, 0, 0, 8, 1);
      ex_vx[0] = -16; ex_vx[1] = 16;
      go_a(4'b0011, 1);
      repeat (40) @(negedge clk);
      check_eq("a_busy_mid_pass", longint'(busy_a), 1);
      start_a = 1'b1;
      vel_x_a = '1;
      @(negedge clk);
      start_a = 1'b0;
      drain_a(600);
      repeat (300) @(posedge clk);
      @(negedge clk);
      check_eq("a_busy_after_pass", longint'(busy_a), 0);

      // Separating pair: no collision, minimum latency
      set_car(0, 0, 0, -16, 0, 8, 1);
      set_car(1, 10, 0, 16, 0, 8, 1);
      set_car(2, 1000, 1000, 0, 0, 8, 1);
      set_car(3, -1000, -1000, 0, 0, 8, 1);
      go_a(4'b0000, 0);
      drain_a(100);

      // Unequal mass
      set_car(0, 0, 0, 16, 0, 8, 3);
      set_car(1, 10, 0, 0, 0, 8, 1);
      ex_vx[0] = 8; ex_vx[1] = 24;
      go_a(4'b0011, 1);
      drain_a(600);

      // Chain: pair (1,2) must see car1 updated by pair (0,1)
      set_car(0, 0, 0, 16, 0, 8, 1);
      set_car(1, 10, 0, 0, 0, 8, 1);
      set_car(2, 20, 0, 0, 0, 8, 1);
      set_car(3, -1000, -1000, 0, 0, 8, 1);
      ex_vx[0] = 0; ex_vx[1] = 0; ex_vx[2] = 16;
      go_a(4'b0111, 2);
      drain_a(1000);

      // Reset during DIV aborts the pass with no o_done
      set_car(0, 0, 0, 16, 0, 8, 1);
      set_car(1, 10, 0, -16, 0, 8, 1);
      set_car(2, 1000, 1000, 0, 0, 8, 1);
      set_car(3, -1000, -1000, 0, 0, 8, 1);
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (100) @(negedge clk);
      check_eq("abort_busy_before", longint'(busy_a), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_eq("abort_vx", longint'(out_vx_a), 0);
      check_eq("abort_vy", longint'(out_vy_a), 0);
      check_eq("abort_mask", longint'(hit_a), 0);
      check_eq("abort_busy", longint'(busy_a), 0);
      check_eq("abort_done", longint'(done_a), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (300) @(posedge clk);

      // Fresh pass after reset
      ex_vx[0] = -16; ex_vx[1] = 16;
      go_a(4'b0011, 1);
      drain_a(600);

      // Instance B: truncation toward zero and positive saturation
      pos_x_b = {PW'(10), PW'(0)};
      pos_y_b = '0;
      vel_x_b = {VWB'(0), VWB'(100)};
      vel_y_b = '0;
      rad_b   = {RW'(8), RW'(8)};
      mass_b  = {MWB'(1), MWB'(15)};
      @(negedge clk);
      eb.vx   = {VWB'(127), VWB'(87)};
      eb.vy   = '0;
      eb.mask = 2'b11;
      eb.lat  = 2 + 2*PB + COLL_CY;
      eb.t0   = cyc;
      sb_b.push_back(eb);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      begin
         int n = 0;
         while (sb_b.size() != 0 && n < 600) begin
            @(posedge clk);
            n++;
         end
         if (sb_b.size() != 0) begin
            check_eq("b_timeout_pending", sb_b.size(), 0);
            sb_b.delete();
         end
      end
      repeat (3) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
